// File: rtl/plugboard_mapper.sv
// Enigma plugboard: involutive 26-letter swap table with cable
// programming commands and a one-cycle pipelined letter lookup.
module plugboard_mapper #(
  parameter int MAX_PAIRS = 10
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        PAIR_VALID,
  input  logic [25:0] PAIR_A,
  input  logic [25:0] PAIR_B,
  input  logic        CLEAR,
  output logic        PAIR_READY,
  output logic        PAIR_DONE,
  output logic        PAIR_ERROR,
  output logic [3:0]  PAIR_COUNT,
  input  logic        LETTER_VALID,
  input  logic [25:0] LETTER_IN,
  output logic [25:0] LETTER_OUT,
  output logic        LETTER_OUT_VALID
);

  typedef enum logic [1:0] {
    IDLE, UNPLUG, PLUG, DONE
  } state_t;

  state_t state, next;

  logic [4:0] partner [26];
  logic [4:0] nt [26];
  logic [4:0] a_q, b_q, pa, pb;
  logic [3:0] cnt_q;
  logic [4:0] ia, ib, lidx;
  logic [4:0] new_cnt;
  logic       pair_ok, fits;
  logic       a_plugged, b_extra;
  logic       letter_ok;
  logic       do_clear, accept, pair_err;

  function automatic logic is_onehot(logic [25:0] v);
    return (v != '0) && ((v & (v - 26'd1)) == '0);
  endfunction

  function automatic logic [4:0] to_idx(logic [25:0] v);
    logic [4:0] r;
    r = '0;
    for (int i = 0; i < 26; i++)
      if (v[i]) r = r | 5'(i);
    return r;
  endfunction

  always_comb begin
    ia        = to_idx(PAIR_A);
    ib        = to_idx(PAIR_B);
    lidx      = to_idx(LETTER_IN);
    letter_ok = is_onehot(LETTER_IN);
    pair_ok   = is_onehot(PAIR_A) && is_onehot(PAIR_B);
    a_plugged = partner[ia] != ia;
    // B's cable only counts separately when it is not A's own cable
    b_extra   = (ib != ia) && (partner[ib] != ib)
              && (partner[ib] != ia);
    new_cnt   = 5'(PAIR_COUNT) - 5'(a_plugged)
              - 5'(b_extra) + 5'(ia != ib);
    fits      = new_cnt <= 5'(MAX_PAIRS);
    do_clear  = (state == IDLE) && CLEAR;
    accept    = (state == IDLE) && !CLEAR && PAIR_VALID
              && pair_ok && fits;
    pair_err  = (state == IDLE) && !CLEAR && PAIR_VALID
              && !(pair_ok && fits);
  end

  // Post-command table, committed in one shot at PLUG->DONE
  always_comb begin
    nt = partner;
    pa = partner[a_q];
    pb = partner[b_q];
    nt[pa]  = pa;
    nt[pb]  = pb;
    nt[a_q] = a_q;
    nt[b_q] = b_q;
    if (a_q != b_q) begin
      nt[a_q] = b_q;
      nt[b_q] = a_q;
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE:    if (accept) next = UNPLUG;
      UNPLUG:  next = PLUG;
      PLUG:    next = DONE;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  assign PAIR_READY = (state == IDLE);

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 26; i++)
        partner[i] <= 5'(i);
      a_q              <= '0;
      b_q              <= '0;
      cnt_q            <= '0;
      PAIR_COUNT       <= '0;
      PAIR_DONE        <= 1'b0;
      PAIR_ERROR       <= 1'b0;
      LETTER_OUT       <= '0;
      LETTER_OUT_VALID <= 1'b0;
    end else begin
      PAIR_DONE  <= do_clear || (state == PLUG);
      PAIR_ERROR <= pair_err || (LETTER_VALID && !letter_ok);
      LETTER_OUT_VALID <= LETTER_VALID;
      if (LETTER_VALID)
        LETTER_OUT <= letter_ok ? (26'd1 << partner[lidx]) : '0;
      if (do_clear) begin
        for (int i = 0; i < 26; i++)
          partner[i] <= 5'(i);
        PAIR_COUNT <= '0;
      end else if (accept) begin
        a_q   <= ia;
        b_q   <= ib;
        cnt_q <= new_cnt[3:0];
      end
      if (state == PLUG) begin
        partner    <= nt;
        PAIR_COUNT <= cnt_q;
      end
    end
  end

endmodule

// File: tb/tb_plugboard_mapper.sv
// Self-checking bench for plugboard_mapper against a cable-list
// model of the plugboard, with directed and random commands.
module tb_plugboard_mapper;

  localparam int MAXP = 10;

  logic        CLOCK;
  logic        RESET;
  logic        PAIR_VALID;
  logic [25:0] PAIR_A;
  logic [25:0] PAIR_B;
  logic        CLEAR;
  logic        PAIR_READY;
  logic        PAIR_DONE;
  logic        PAIR_ERROR;
  logic [3:0]  PAIR_COUNT;
  logic        LETTER_VALID;
  logic [25:0] LETTER_IN;
  logic [25:0] LETTER_OUT;
  logic        LETTER_OUT_VALID;

  int checks = 0;
  int fails  = 0;
  int mp [26];

  plugboard_mapper #(.MAX_PAIRS(MAXP)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .PAIR_VALID(PAIR_VALID), .PAIR_A(PAIR_A),
    .PAIR_B(PAIR_B), .CLEAR(CLEAR),
    .PAIR_READY(PAIR_READY), .PAIR_DONE(PAIR_DONE),
    .PAIR_ERROR(PAIR_ERROR), .PAIR_COUNT(PAIR_COUNT),
    .LETTER_VALID(LETTER_VALID), .LETTER_IN(LETTER_IN),
    .LETTER_OUT(LETTER_OUT),
    .LETTER_OUT_VALID(LETTER_OUT_VALID)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [25:0] oh(int i);
    logic [25:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int idx_of(logic [25:0] v);
    for (int i = 0; i < 26; i++)
      if (v[i]) return i;
    return 0;
  endfunction

  function automatic int model_count();
    int n;
    n = 0;
    for (int i = 0; i < 26; i++)
      if (mp[i] > i) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 26; i++) mp[i] = i;
  endtask

  // Pull out any cable on a or b, then plug a-b; reject if too many.
  task automatic model_apply(input int a, input int b,
                             output bit err);
    int t [26];
    int n;
    t = mp;
    if (t[a] != a) begin t[t[a]] = t[a]; t[a] = a; end
    if (t[b] != b) begin t[t[b]] = t[b]; t[b] = b; end
    if (a != b) begin t[a] = b; t[b] = a; end
    n = 0;
    for (int i = 0; i < 26; i++)
      if (t[i] > i) n++;
    err = n > MAXP;
    if (!err) mp = t;
  endtask

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic lookup(input logic [25:0] v,
                        output logic [25:0] o,
                        output logic ov, output logic er);
    LETTER_IN = v;
    LETTER_VALID = 1'b1;
    step();
    o  = LETTER_OUT;
    ov = LETTER_OUT_VALID;
    er = PAIR_ERROR;
    LETTER_VALID = 1'b0;
  endtask

  // Returns the number of edges until PAIR_DONE (or 1 on error)
  task automatic pair_cmd(input logic [25:0] a,
                          input logic [25:0] b,
                          output logic er, output int n);
    PAIR_A = a;
    PAIR_B = b;
    PAIR_VALID = 1'b1;
    step();
    PAIR_VALID = 1'b0;
    er = PAIR_ERROR;
    n = 1;
    if (!er) begin
      while (!PAIR_DONE && n < 8) begin
        step();
        n++;
      end
      step();
    end
  endtask

  task automatic test_reset();
    logic [25:0] o;
    logic ov, er;
    RESET = 1'b1;
    PAIR_VALID = 0; CLEAR = 0; LETTER_VALID = 0;
    PAIR_A = '0; PAIR_B = '0; LETTER_IN = '0;
    #12;
    RESET = 1'b0;
    model_reset();
    step();
    checks++;
    if (PAIR_COUNT !== 4'd0 || PAIR_READY !== 1'b1) begin
      fails++;
      $display("FAIL reset_state: count=%0d ready=%b want 0 1",
               PAIR_COUNT, PAIR_READY);
    end
    checks++;
    if (LETTER_OUT !== '0 || LETTER_OUT_VALID !== 1'b0
        || PAIR_DONE !== 1'b0 || PAIR_ERROR !== 1'b0) begin
      fails++;
      $display("FAIL reset_outs: out=%h v=%b d=%b e=%b want 0",
               LETTER_OUT, LETTER_OUT_VALID, PAIR_DONE, PAIR_ERROR);
    end
    for (int i = 0; i < 26; i++) begin
      lookup(oh(i), o, ov, er);
      checks++;
      if (o !== oh(i) || ov !== 1'b1) begin
        fails++;
        $display("FAIL identity[%0d]: got %h v=%b want %h v=1",
                 i, o, ov, oh(i));
      end
    end
    step();
    checks++;
    if (LETTER_OUT_VALID !== 1'b0 || LETTER_OUT !== oh(25)) begin
      fails++;
      $display("FAIL out_hold: got %h v=%b want %h v=0",
               LETTER_OUT, LETTER_OUT_VALID, oh(25));
    end
  endtask

  task automatic test_plug_basic();
    logic [25:0] o;
    logic ov, er;
    int n;
    bit me;
    pair_cmd(oh(0), oh(16), er, n);
    model_apply(0, 16, me);
    checks++;
    if (er !== 1'b0 || n != 3) begin
      fails++;
      $display("FAIL plug_aq: err=%b done_edges=%0d want 0 3",
               er, n);
    end
    checks++;
    if (PAIR_COUNT !== 4'd1 || PAIR_READY !== 1'b1) begin
      fails++;
      $display("FAIL plug_aq_count: got %0d rdy=%b want 1 1",
               PAIR_COUNT, PAIR_READY);
    end
    foreach (mp[i]) begin
      if (i == 0 || i == 16 || i == 1) begin
        lookup(oh(i), o, ov, er);
        checks++;
        if (o !== oh(mp[i])) begin
          fails++;
          $display("FAIL plug_aq_lookup[%0d]: got %h want %h",
                   i, o, oh(mp[i]));
        end
      end
    end
  endtask

  task automatic test_replug();
    logic [25:0] o;
    logic ov, er;
    int n;
    bit me;
    pair_cmd(oh(0), oh(2), er, n);
    model_apply(0, 2, me);
    checks++;
    if (er !== 1'b0 || PAIR_COUNT !== 4'd1) begin
      fails++;
      $display("FAIL replug_ac: err=%b count=%0d want 0 1",
               er, PAIR_COUNT);
    end
    for (int i = 0; i < 26; i++) begin
      lookup(oh(i), o, ov, er);
      checks++;
      if (o !== oh(mp[i])) begin
        fails++;
        $display("FAIL replug_ac[%0d]: got %h want %h",
                 i, o, oh(mp[i]));
      end
    end
    pair_cmd(oh(0), oh(0), er, n);
    model_apply(0, 0, me);
    checks++;
    if (er !== 1'b0 || PAIR_COUNT !== 4'd0 || n != 3) begin
      fails++;
      $display("FAIL unplug_a: err=%b count=%0d n=%0d want 0 0 3",
               er, PAIR_COUNT, n);
    end
    for (int i = 0; i < 3; i++) begin
      lookup(oh(i), o, ov, er);
      checks++;
      if (o !== oh(i)) begin
        fails++;
        $display("FAIL unplug_a[%0d]: got %h want %h",
                 i, o, oh(i));
      end
    end
  endtask

  task automatic test_capacity();
    logic [25:0] o;
    logic ov, er;
    int n;
    bit me;
    for (int k = 0; k < 10; k++) begin
      pair_cmd(oh(2 * k), oh(2 * k + 1), er, n);
      model_apply(2 * k, 2 * k + 1, me);
      checks++;
      if (er !== 1'b0 || n != 3) begin
        fails++;
        $display("FAIL cap_plug[%0d]: err=%b n=%0d want 0 3",
                 k, er, n);
      end
    end
    checks++;
    if (PAIR_COUNT !== 4'd10) begin
      fails++;
      $display("FAIL cap_count: got %0d want 10", PAIR_COUNT);
    end
    pair_cmd(oh(20), oh(21), er, n);
    model_apply(20, 21, me);
    checks++;
    if (er !== 1'b1 || me != 1'b1 || PAIR_COUNT !== 4'd10) begin
      fails++;
      $display("FAIL cap_reject: err=%b count=%0d want 1 10",
               er, PAIR_COUNT);
    end
    step();
    pair_cmd(oh(1), oh(20), er, n);
    model_apply(1, 20, me);
    checks++;
    if (er !== 1'b0 || PAIR_COUNT !== 4'd10) begin
      fails++;
      $display("FAIL cap_move: err=%b count=%0d want 0 10",
               er, PAIR_COUNT);
    end
    for (int i = 0; i < 26; i++) begin
      lookup(oh(i), o, ov, er);
      checks++;
      if (o !== oh(mp[i])) begin
        fails++;
        $display("FAIL cap_table[%0d]: got %h want %h",
                 i, o, oh(mp[i]));
      end
    end
  endtask

  task automatic test_bad_input();
    logic [25:0] o;
    logic ov, er;
    int n;
    logic [3:0] c0;
    c0 = PAIR_COUNT;
    pair_cmd(26'h3, oh(5), er, n);
    checks++;
    if (er !== 1'b1 || n != 1 || PAIR_COUNT !== c0) begin
      fails++;
      $display("FAIL bad_pair: err=%b n=%0d count=%0d want 1 1 %0d",
               er, n, PAIR_COUNT, c0);
    end
    step();
    checks++;
    if (PAIR_ERROR !== 1'b0) begin
      fails++;
      $display("FAIL err_pulse: got %b want 0", PAIR_ERROR);
    end
    lookup('0, o, ov, er);
    checks++;
    if (o !== '0 || ov !== 1'b1 || er !== 1'b1) begin
      fails++;
      $display("FAIL bad_letter: out=%h v=%b e=%b want 0 1 1",
               o, ov, er);
    end
    lookup(oh(5), o, ov, er);
    checks++;
    if (o !== oh(mp[5]) || er !== 1'b0) begin
      fails++;
      $display("FAIL after_bad: got %h e=%b want %h 0",
               o, er, oh(mp[5]));
    end
  endtask

  task automatic test_commit_timing();
    logic [25:0] o;
    logic [25:0] want;
    logic ov, er;
    int n;
    bit me;
    CLEAR = 1'b1;
    PAIR_A = oh(3); PAIR_B = oh(4);
    PAIR_VALID = 1'b1;
    step();
    CLEAR = 1'b0;
    PAIR_VALID = 1'b0;
    model_reset();
    checks++;
    if (PAIR_DONE !== 1'b1 || PAIR_COUNT !== 4'd0
        || PAIR_ERROR !== 1'b0 || PAIR_READY !== 1'b1) begin
      fails++;
      $display("FAIL clear: done=%b count=%0d err=%b rdy=%b",
               PAIR_DONE, PAIR_COUNT, PAIR_ERROR, PAIR_READY);
    end
    PAIR_A = oh(4); PAIR_B = oh(25);
    PAIR_VALID = 1'b1;
    LETTER_IN = oh(4);
    LETTER_VALID = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      PAIR_VALID = 1'b0;
      want = (k <= 3) ? oh(4) : oh(25);
      checks++;
      if (LETTER_OUT !== want || LETTER_OUT_VALID !== 1'b1
          || PAIR_DONE !== (k == 3)) begin
        fails++;
        $display("FAIL commit[%0d]: out=%h v=%b d=%b want %h 1 %b",
                 k, LETTER_OUT, LETTER_OUT_VALID, PAIR_DONE,
                 want, (k == 3));
      end
    end
    LETTER_VALID = 1'b0;
    model_apply(4, 25, me);
    PAIR_A = oh(1); PAIR_B = oh(2);
    PAIR_VALID = 1'b1;
    step();
    PAIR_VALID = 1'b0;
    step();
    RESET = 1'b1;
    #2;
    RESET = 1'b0;
    model_reset();
    checks++;
    if (PAIR_COUNT !== 4'd0 || LETTER_OUT !== '0
        || LETTER_OUT_VALID !== 1'b0 || PAIR_READY !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset: count=%0d out=%h v=%b rdy=%b",
               PAIR_COUNT, LETTER_OUT, LETTER_OUT_VALID, PAIR_READY);
    end
    for (int i = 0; i < 26; i++) begin
      lookup(oh(i), o, ov, er);
      checks++;
      if (o !== oh(i)) begin
        fails++;
        $display("FAIL reset_table[%0d]: got %h want %h",
                 i, o, oh(i));
      end
    end
    pair_cmd(oh(7), oh(9), er, n);
    model_apply(7, 9, me);
    pair_cmd(oh(11), oh(13), er, n);
    model_apply(11, 13, me);
    CLEAR = 1'b1;
    step();
    CLEAR = 1'b0;
    model_reset();
    checks++;
    if (PAIR_COUNT !== 4'd0 || PAIR_DONE !== 1'b1) begin
      fails++;
      $display("FAIL clear2: count=%0d done=%b want 0 1",
               PAIR_COUNT, PAIR_DONE);
    end
    for (int i = 7; i < 14; i++) begin
      lookup(oh(i), o, ov, er);
      checks++;
      if (o !== oh(i)) begin
        fails++;
        $display("FAIL clear_table[%0d]: got %h want %h",
                 i, o, oh(i));
      end
    end
  endtask

  task automatic test_random();
    logic [25:0] va, vb, o, o2;
    logic ov, er;
    int a, b, x, n;
    bit me;
    for (int it = 0; it < 80; it++) begin
      a = $urandom_range(0, 25);
      b = ($urandom_range(0, 4) == 0) ? a : $urandom_range(0, 25);
      va = oh(a);
      vb = oh(b);
      if ($urandom_range(0, 9) == 0) va = 26'($urandom());
      if ($urandom_range(0, 14) == 0) vb = '0;
      if ($countones(va) == 1 && $countones(vb) == 1)
        model_apply(idx_of(va), idx_of(vb), me);
      else
        me = 1'b1;
      pair_cmd(va, vb, er, n);
      checks++;
      if (er !== me || (!me && n != 3)) begin
        fails++;
        $display("FAIL rnd_cmd[%0d]: err=%b n=%0d want %b 3",
                 it, er, n, me);
      end
      checks++;
      if (PAIR_COUNT !== 4'(model_count())) begin
        fails++;
        $display("FAIL rnd_count[%0d]: got %0d want %0d",
                 it, PAIR_COUNT, model_count());
      end
      for (int j = 0; j < 2; j++) begin
        x = $urandom_range(0, 25);
        lookup(oh(x), o, ov, er);
        lookup(o, o2, ov, er);
        checks++;
        if (o !== oh(mp[x]) || o2 !== oh(x)) begin
          fails++;
          $display("FAIL rnd_lookup[%0d]: %0d->%h->%h want %h",
                   it, x, o, o2, oh(mp[x]));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_plug_basic();
    test_replug();
    test_capacity();
    test_bad_input();
    test_commit_timing();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
